// File: rtl/dd_bcd_bin_conv_pkg.sv
// Shared constants, state encodings and width helpers for the iterative
// double-dabble BCD<->binary converter.
package dd_conv_pkg;

    // Per-transaction direction select.
    localparam logic MODE_D2B = 1'b0;
    localparam logic MODE_B2D = 1'b1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHFT = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    typedef struct packed {
        logic ovf;
        logic inv;
    } dd_err_t;

    // Digits needed for a WID-bit binary value, rounded up to whole nibbles.
    function automatic int fnBcdWid(input int wid);
        return ((wid + (wid - 4) / 3) + 3) & ~3;
    endfunction

    function automatic int fnIter(input int wid, input int dep);
        return (wid + dep - 1) / dep;
    endfunction

endpackage

// File: rtl/dd_bcd_bin_conv_if.sv
// Request/response bundle for dd_bcd_bin_conv: valid/ready on both sides plus
// the converted result, error flags and busy indication.
interface dd_bcd_bin_conv_if #(
    parameter int WID = 128
) ();
    import dd_conv_pkg::*;

    localparam int BCDWID = fnBcdWid(WID);

    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic [BCDWID-1:0] din;
    logic              out_valid;
    logic              out_ready;
    logic [BCDWID-1:0] dout;
    logic [1:0]        err;
    logic              busy;

    modport master (
        output in_valid, mode, din, out_ready,
        input  in_ready, out_valid, dout, err, busy
    );

    modport slave (
        input  in_valid, mode, din, out_ready,
        output in_ready, out_valid, dout, err, busy
    );

endinterface

// File: rtl/dd_bcd_bin_conv_row.sv
// One combinational dabble step, both directions: reverse dabble (shift right,
// then -3 on nibbles >= 8) or forward dabble (+3 on nibbles >= 5, then shift left).
module dd_conv_row
    import dd_conv_pkg::*;
#(
    parameter int BCDWID = 44
) (
    input  logic              mode,
    input  logic [BCDWID-1:0] bcd_i,
    input  logic              bit_i,
    output logic [BCDWID-1:0] bcd_o,
    output logic              bit_o
);

    localparam int NDIG = BCDWID / 4;

    logic [BCDWID-1:0] sr;
    logic [BCDWID-1:0] adj;

    always_comb begin
        sr  = {1'b0, bcd_i[BCDWID-1:1]};
        adj = bcd_i;
        for (int d = 0; d < NDIG; d++) begin
            if (sr[4*d +: 4] >= 4'd8)
                sr[4*d +: 4] = sr[4*d +: 4] - 4'd3;
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        if (mode == MODE_D2B) begin
            bcd_o = sr;
            bit_o = bcd_i[0];
        end else begin
            bcd_o = {adj[BCDWID-2:0], bit_i};
            bit_o = adj[BCDWID-1];
        end
    end

endmodule

// File: rtl/dd_bcd_bin_conv.sv
// Iterative double-dabble converter, DEP dabble steps per clock, ITER clocks per
// result. Define DD_ERRCHK_EN to build the invalid-digit and overflow flags.
module dd_bcd_bin_conv
    import dd_conv_pkg::*;
#(
    parameter int WID = 128,
    parameter int DEP = 2
) (
    input logic              clk,
    input logic              rst,
    dd_bcd_bin_conv_if.slave bus
);

    localparam int BCDWID = fnBcdWid(WID);
    localparam int ITER   = fnIter(WID, DEP);
    localparam int PADW   = ITER * DEP;
    localparam int CNTW   = (ITER > 1) ? $clog2(ITER) : 1;

    logic [1:0]        state;
    logic              mode_r;
    logic [BCDWID-1:0] bcd_r;
    logic [BCDWID-1:0] bcd_nx;
    logic [PADW-1:0]   bin_r;
    logic [PADW-1:0]   bin_nx;
    logic [CNTW-1:0]   cnt;
    logic [BCDWID-1:0] dout_r;
    logic [BCDWID-1:0] res;
    logic              acc;
    logic              last;

    // A finished result can hand over straight to the next request.
    assign bus.in_ready  = (state == IDLE) || ((state == OUT) && bus.out_ready);
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state == SHFT);
    assign bus.dout      = dout_r;

    assign acc  = bus.in_valid && bus.in_ready;
    assign last = (state == SHFT) && (cnt == '0);

    for (genvar g = 0; g < DEP; g++) begin : g_row
        logic [BCDWID-1:0] bcd_i;
        logic [BCDWID-1:0] bcd_o;
        logic [PADW-1:0]   bin_i;
        logic [PADW-1:0]   bin_o;
        logic              bit_o;

        if (g == 0) begin : g_head
            assign bcd_i = bcd_r;
            assign bin_i = bin_r;
        end else begin : g_tail
            assign bcd_i = g_row[g-1].bcd_o;
            assign bin_i = g_row[g-1].bin_o;
        end

        dd_conv_row #(.BCDWID(BCDWID)) u_row (
            .mode  (mode_r),
            .bcd_i (bcd_i),
            .bit_i (bin_i[PADW-1]),
            .bcd_o (bcd_o),
            .bit_o (bit_o)
        );

        // Reverse dabble feeds the BCD LSB into the binary MSB; forward dabble
        // hands the binary MSB to the BCD side and shifts left.
        assign bin_o = (mode_r == MODE_B2D) ? {bin_i[PADW-2:0], 1'b0}
                                            : {bit_o, bin_i[PADW-1:1]};
    end

    assign bcd_nx = g_row[DEP-1].bcd_o;
    assign bin_nx = g_row[DEP-1].bin_o;
    assign res    = (mode_r == MODE_B2D) ? bcd_nx : BCDWID'(bin_nx[WID-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_r <= MODE_D2B;
            bcd_r  <= '0;
            bin_r  <= '0;
            cnt    <= '0;
            dout_r <= '0;
        end else if (acc) begin
            state  <= SHFT;
            mode_r <= bus.mode;
            cnt    <= CNTW'(ITER - 1);
            if (bus.mode == MODE_B2D) begin
                bcd_r <= '0;
                bin_r <= PADW'(bus.din[WID-1:0]);
            end else begin
                bcd_r <= bus.din;
                bin_r <= '0;
            end
        end else begin
            case (state)
                SHFT: begin
                    bcd_r <= bcd_nx;
                    bin_r <= bin_nx;
                    if (cnt == '0) begin
                        state  <= OUT;
                        dout_r <= res;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DD_ERRCHK_EN
    localparam int NDIG = BCDWID / 4;

    logic    inv_din;
    logic    inv_r;
    dd_err_t err_r;

    always_comb begin
        inv_din = 1'b0;
        for (int d = 0; d < NDIG; d++)
            if (bus.din[4*d +: 4] > 4'd9)
                inv_din = 1'b1;
    end

    // Overflow: decimal value left over in the BCD register or in the pad bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_r <= 1'b0;
            err_r <= '0;
        end else begin
            if (acc)
                inv_r <= (bus.mode == MODE_D2B) && inv_din;
            if (last) begin
                err_r.inv <= inv_r;
                err_r.ovf <= (mode_r == MODE_D2B) &&
                             ((|bcd_nx) || (|(bin_nx >> WID)));
            end
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 2'b00;
`endif

endmodule

// File: tb/tb_dd_bcd_bin_conv.sv
// Scoreboard bench for dd_bcd_bin_conv: WID=32 with DEP=2 (unit 0) and DEP=3 (unit 1).
module tb_dd_bcd_bin_conv;
    import dd_conv_pkg::*;

`ifdef DD_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    typedef struct {
        logic [43:0] d;
        logic [1:0]  e;
        bit          chk_d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   acc_cyc [2];
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dd_bcd_bin_conv_if #(.WID(32)) ifa ();
    dd_bcd_bin_conv_if #(.WID(32)) ifb ();

    dd_bcd_bin_conv #(.WID(32), .DEP(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    dd_bcd_bin_conv #(.WID(32), .DEP(3)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [43:0] to_bcd(input longint unsigned v);
        logic [43:0]     r;
        longint unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 11; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int iter_of(input int u);
        return (u == 0) ? 16 : 11;
    endfunction

    task automatic drive(input int u, input logic iv, input logic md, input logic [43:0] d);
        if (u == 0) begin
            ifa.in_valid = iv; ifa.mode = md; ifa.din = d;
        end else begin
            ifb.in_valid = iv; ifb.mode = md; ifb.din = d;
        end
    endtask

    // Present a request, wait for it to be taken, scramble inputs afterwards.
    task automatic send(input int u, input logic md, input logic [43:0] d,
                        input logic [43:0] ed, input logic [1:0] ee, input bit chk_d);
        int   n;
        bit   ok;
        exp_t x;
        n  = 0;
        ok = 0;
        @(posedge clk); #1;
        drive(u, 1'b1, md, d);
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if ((u == 0) ? ifa.in_ready : ifb.in_ready) begin
                ok = 1;
                acc_cyc[u] = cyc + 1;
            end
        end
        @(posedge clk); #1;
        drive(u, 1'b0, ~md, ~d);
        x.d = ed; x.e = ee; x.chk_d = chk_d;
        if (u == 0) qa.push_back(x); else qb.push_back(x);
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept u%0d: got no in_ready, want accept within 200 cycles", u);
        end
    endtask

    task automatic wait_out(input int u, output logic [43:0] d, output logic [1:0] e, output int lat);
        int n;
        bit seen;
        n = 0; seen = 0;
        d = 'x; e = 'x;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if ((u == 0) ? ifa.out_valid : ifb.out_valid) begin
                seen = 1;
                d = (u == 0) ? ifa.dout : ifb.dout;
                e = (u == 0) ? ifa.err : ifb.err;
            end
        end
        lat = seen ? (cyc - acc_cyc[u]) : -1;
    endtask

    task automatic take(input int u, output exp_t x);
        if (u == 0) x = qa.pop_front(); else x = qb.pop_front();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            logic [2:0]  fl;
            logic [45:0] de;
            fl = (u == 0) ? {ifa.in_ready, ifa.out_valid, ifa.busy} : {ifb.in_ready, ifb.out_valid, ifb.busy};
            de = (u == 0) ? {ifa.dout, ifa.err} : {ifb.dout, ifb.err};
            tests++;
            if (fl !== 3'b100) begin
                fails++; $display("FAIL reset_flags u%0d: got rdy/ov/busy %b, want 100", u, fl);
            end
            tests++;
            if (de !== 46'h0) begin
                fails++; $display("FAIL reset_dout_err u%0d: got %h, want 0", u, de);
            end
        end
    endtask

    // Table-driven conversions: each entry is {unit, mode, din, expected dout}.
    task automatic test_convert;
        int          un [7]  = '{0, 0, 0, 0, 0, 1, 1};
        logic        md [7]  = '{MODE_D2B, MODE_D2B, MODE_B2D, MODE_B2D, MODE_B2D, MODE_D2B, MODE_B2D};
        logic [43:0] di [7]  = '{44'h04294967295, 44'h00000000099, 44'h000FFFFFFFF, 44'h0,
                                 44'hABC00000064, 44'h00000012345, 44'h000075BCD15};
        logic [43:0] ex [7]  = '{44'h000FFFFFFFF, 44'h00000000063, 44'h04294967295, 44'h0,
                                 44'h00000000100, 44'h00000003039, 44'h00123456789};
        logic [43:0] gd;
        logic [1:0]  ge;
        int          lat;
        exp_t        x;
        for (int i = 0; i < 7; i++) begin
            send(un[i], md[i], di[i], ex[i], 2'b00, 1);
            wait_out(un[i], gd, ge, lat);
            take(un[i], x);
            tests++;
            if (gd !== x.d) begin fails++; $display("FAIL conv%0d dout: got %h, want %h", i, gd, x.d); end
            tests++;
            if (ge !== x.e) begin fails++; $display("FAIL conv%0d err: got %b, want %b", i, ge, x.e); end
            tests++;
            if (lat !== iter_of(un[i])) begin
                fails++; $display("FAIL conv%0d latency: got %0d, want %0d", i, lat, iter_of(un[i]));
            end
        end
        // Round trip through the DEP=3 unit.
        send(1, MODE_D2B, 44'h00123456789, 44'h000075BCD15, 2'b00, 1);
        wait_out(1, gd, ge, lat);
        take(1, x);
        tests++;
        if (gd !== x.d) begin fails++; $display("FAIL roundtrip dout: got %h, want %h", gd, x.d); end
    endtask

    task automatic test_errflags;
        int          un [5] = '{0, 0, 0, 1, 0};
        logic [43:0] di [5];
        logic [43:0] ex [5];
        logic [1:0]  ee [5];
        bit          cd [5] = '{1, 0, 1, 1, 1};
        logic [43:0] gd;
        logic [1:0]  ge;
        int          lat;
        exp_t        x;
        longint unsigned big;
        big = 64'd99999999999;
        di = '{44'h04294967296, 44'h000000012A4, to_bcd(big), 44'h04294967296, 44'h99999999999};
        ex = '{44'h0, 44'h0, {12'h0, big[31:0]}, 44'h0, {12'h0, big[31:0]}};
        ee = '{ERRCHK ? 2'b10 : 2'b00, ERRCHK ? 2'b01 : 2'b00, ERRCHK ? 2'b10 : 2'b00,
               ERRCHK ? 2'b10 : 2'b00, ERRCHK ? 2'b10 : 2'b00};
        for (int i = 0; i < 5; i++) begin
            send(un[i], MODE_D2B, di[i], ex[i], ee[i], cd[i]);
            wait_out(un[i], gd, ge, lat);
            take(un[i], x);
            tests++;
            if (ge !== x.e) begin fails++; $display("FAIL err%0d flags: got %b, want %b", i, ge, x.e); end
            if (x.chk_d) begin
                tests++;
                if (gd !== x.d) begin fails++; $display("FAIL err%0d dout: got %h, want %h", i, gd, x.d); end
            end
        end
    endtask

    task automatic test_random;
        logic [43:0]     gd;
        logic [1:0]      ge;
        int              lat;
        exp_t            x;
        longint unsigned v;
        for (int i = 0; i < 8; i++) begin
            int u;
            u = i % 2;
            v = longint'($urandom);
            if (i < 4) send(u, MODE_B2D, {12'h0, v[31:0]}, to_bcd(v), 2'b00, 1);
            else       send(u, MODE_D2B, to_bcd(v), {12'h0, v[31:0]}, 2'b00, 1);
            wait_out(u, gd, ge, lat);
            take(u, x);
            tests++;
            if (gd !== x.d || ge !== x.e) begin
                fails++; $display("FAIL rand%0d: got %h/%b, want %h/%b", i, gd, ge, x.d, x.e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [43:0] gd;
        logic [1:0]  ge;
        int          lat;
        exp_t        x;
        exp_t        y;
        ifa.out_ready = 1'b0;
        send(0, MODE_B2D, 44'h000FFFFFFFF, 44'h04294967295, 2'b00, 1);
        wait_out(0, gd, ge, lat);
        take(0, x);
        tests++;
        if (gd !== x.d || lat !== 16) begin
            fails++; $display("FAIL bp_first: got %h lat %0d, want %h lat 16", gd, lat, x.d);
        end
        drive(0, 1'b1, MODE_D2B, 44'h00000000099);
        y.d = 44'h63; y.e = 2'b00; y.chk_d = 1;
        qa.push_back(y);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (ifa.dout !== x.d || ifa.err !== x.e || ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: got dout %h err %b rdy %b ov %b, want %h %b 0 1",
                         i, ifa.dout, ifa.err, ifa.in_ready, ifa.out_valid, x.d, x.e);
            end
        end
        ifa.out_ready = 1'b1;
        #1;
        tests++;
        if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy: got %b, want 1", ifa.in_ready); end
        acc_cyc[0] = cyc + 1;
        @(posedge clk); #1;
        drive(0, 1'b0, MODE_B2D, 44'hFFFFFFFFFFF);
        tests++;
        if (ifa.busy !== 1'b1 || ifa.out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_direct: got busy %b ov %b, want 1 0", ifa.busy, ifa.out_valid);
        end
        wait_out(0, gd, ge, lat);
        take(0, x);
        tests++;
        if (gd !== x.d || ge !== x.e || lat !== 16) begin
            fails++; $display("FAIL bp_second: got %h %b lat %0d, want %h %b lat 16", gd, ge, lat, x.d, x.e);
        end
    endtask

    task automatic test_rst_mid;
        logic [43:0] gd;
        logic [1:0]  ge;
        int          lat;
        exp_t        x;
        send(0, MODE_B2D, 44'h00012345678, 44'h0, 2'b00, 1);
        x = qa.pop_back();
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (ifa.busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy: got %b, want 1", ifa.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({ifa.in_ready, ifa.out_valid, ifa.busy} !== 3'b100 || ifa.dout !== 44'h0 || ifa.err !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_state: got rdy/ov/busy %b dout %h err %b, want 100 0 00",
                     {ifa.in_ready, ifa.out_valid, ifa.busy}, ifa.dout, ifa.err);
        end
        send(0, MODE_D2B, 44'h00000000099, 44'h00000000063, 2'b00, 1);
        wait_out(0, gd, ge, lat);
        take(0, x);
        tests++;
        if (gd !== x.d || ge !== x.e || lat !== 16) begin
            fails++; $display("FAIL rstmid_after: got %h %b lat %0d, want %h %b lat 16", gd, ge, lat, x.d, x.e);
        end
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.mode = MODE_D2B; ifa.din = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.mode = MODE_D2B; ifb.din = '0; ifb.out_ready = 1'b1;
        test_reset;
        test_convert;
        test_errflags;
        test_random;
        test_back_to_back;
        test_rst_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
